// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard for an in-order pipeline: tracks in-flight destination
// registers, steers operand bypass muxes, raises stall/flush and keeps
// saturating stall/flush statistics.
module pipe_scoreboard #(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 3,
    parameter int BR_STAGE   = 1,
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rs,
    input  logic [REG_W-1:0] issue_rt,
    input  logic             issue_rs_used,
    input  logic             issue_rt_used,
    input  logic             issue_wr_en,
    input  logic [REG_W-1:0] issue_wnum,
    input  logic             issue_is_load,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush,
    output logic             load_pc,
    output logic             load_if_id,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel,
    output logic [SEL_W-1:0] inflight,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Entry 0 is execute, entry DEPTH-1 is write-back.
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_wr_en;
    logic [DEPTH-1:0] ent_is_load;
    logic [REG_W-1:0] ent_wnum [DEPTH];

    logic [DEPTH-1:0] nxt_valid;
    logic [SEL_W-1:0] nxt_count;

    logic [REG_W-1:0] src_num  [2];
    logic [1:0]       src_used;
    logic [1:0]       hit;
    logic [1:0]       hit_ld;
    logic [SEL_W-1:0] hit_k    [2];
    logic [1:0]       load_use;
    logic             stall_raw;

    assign src_num[0]  = issue_rs;
    assign src_num[1]  = issue_rt;
    assign src_used[0] = issue_rs_used;
    assign src_used[1] = issue_rt_used;

    // Youngest-match search per source; scanning oldest to youngest lets the
    // lowest index overwrite older hits. Register 0 never matches.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]    = 1'b0;
            hit_ld[s] = 1'b0;
            hit_k[s]  = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (src_used[s] && (src_num[s] != '0) && ent_valid[k] &&
                    ent_wr_en[k] && (ent_wnum[k] == src_num[s])) begin
                    hit[s]    = 1'b1;
                    hit_ld[s] = ent_is_load[k];
                    hit_k[s]  = SEL_W'(k);
                end
            end
            load_use[s] = hit[s] && (hit_k[s] == '0) && hit_ld[s];
        end
    end

    // Hazard, flush and enable decisions; a taken branch overrides any stall.
    always_comb begin
        if (FORWARD_EN != 0)
            stall_raw = issue_valid && (load_use != 2'b00);
        else
            stall_raw = issue_valid && (hit != 2'b00);
        flush      = branch_taken;
        stall      = stall_raw && !branch_taken;
        load_pc    = !stall;
        load_if_id = !stall;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        if ((FORWARD_EN != 0) && issue_valid) begin
            if (hit[0]) fwd_rs_sel = hit_k[0] + SEL_W'(1);
            if (hit[1]) fwd_rt_sel = hit_k[1] + SEL_W'(1);
        end
    end

    // Next valid vector: decode enters entry 0 unless held or squashed; on a
    // flush, instructions younger than the branch are killed as they shift.
    always_comb begin
        nxt_valid[0] = issue_valid && !stall && !flush;
        for (int i = 1; i < DEPTH; i++)
            nxt_valid[i] = ent_valid[i-1] && !(flush && ((i - 1) < BR_STAGE));
        nxt_count = '0;
        for (int i = 0; i < DEPTH; i++)
            nxt_count = nxt_count + SEL_W'(nxt_valid[i]);
    end

    // Scoreboard shift register and the registered occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid   <= '0;
            ent_wr_en   <= '0;
            ent_is_load <= '0;
            for (int i = 0; i < DEPTH; i++) ent_wnum[i] <= '0;
            inflight    <= '0;
        end else begin
            ent_valid      <= nxt_valid;
            ent_wr_en[0]   <= issue_wr_en;
            ent_is_load[0] <= issue_is_load;
            ent_wnum[0]    <= issue_wnum;
            for (int i = 1; i < DEPTH; i++) begin
                ent_wr_en[i]   <= ent_wr_en[i-1];
                ent_is_load[i] <= ent_is_load[i-1];
                ent_wnum[i]    <= ent_wnum[i-1];
            end
            inflight <= nxt_count;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: default build, stall-only build and a
// 2-bit-counter build share one stimulus bus; each scenario checks the build
// it targets.
module tb_pipe_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid = 1'b0;
    logic [4:0] issue_rs = '0, issue_rt = '0, issue_wnum = '0;
    logic       issue_rs_used = 1'b0, issue_rt_used = 1'b0;
    logic       issue_wr_en = 1'b0, issue_is_load = 1'b0;
    logic       branch_taken = 1'b0;

    logic        d_stall, d_flush, d_load_pc, d_load_if_id;
    logic [1:0]  d_fwd_rs, d_fwd_rt, d_inflight;
    logic [15:0] d_stall_cnt, d_flush_cnt;

    logic        n_stall, n_flush, n_load_pc, n_load_if_id;
    logic [1:0]  n_fwd_rs, n_fwd_rt, n_inflight;
    logic [15:0] n_stall_cnt, n_flush_cnt;

    logic        c_stall, c_flush, c_load_pc, c_load_if_id;
    logic [1:0]  c_fwd_rs, c_fwd_rt, c_inflight;
    logic [1:0]  c_stall_cnt, c_flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_scoreboard u_def (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
        .issue_wr_en(issue_wr_en), .issue_wnum(issue_wnum),
        .issue_is_load(issue_is_load), .branch_taken(branch_taken),
        .stall(d_stall), .flush(d_flush), .load_pc(d_load_pc),
        .load_if_id(d_load_if_id), .fwd_rs_sel(d_fwd_rs), .fwd_rt_sel(d_fwd_rt),
        .inflight(d_inflight), .stall_cnt(d_stall_cnt), .flush_cnt(d_flush_cnt)
    );

    pipe_scoreboard #(.FORWARD_EN(0)) u_nf (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
        .issue_wr_en(issue_wr_en), .issue_wnum(issue_wnum),
        .issue_is_load(issue_is_load), .branch_taken(branch_taken),
        .stall(n_stall), .flush(n_flush), .load_pc(n_load_pc),
        .load_if_id(n_load_if_id), .fwd_rs_sel(n_fwd_rs), .fwd_rt_sel(n_fwd_rt),
        .inflight(n_inflight), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    pipe_scoreboard #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
        .issue_wr_en(issue_wr_en), .issue_wnum(issue_wnum),
        .issue_is_load(issue_is_load), .branch_taken(branch_taken),
        .stall(c_stall), .flush(c_flush), .load_pc(c_load_pc),
        .load_if_id(c_load_if_id), .fwd_rs_sel(c_fwd_rs), .fwd_rt_sel(c_fwd_rt),
        .inflight(c_inflight), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rs, input logic rsu,
                             input logic [4:0] rt, input logic rtu, input logic wr,
                             input logic [4:0] wn, input logic ld);
        issue_valid   = v;
        issue_rs      = rs;
        issue_rs_used = rsu;
        issue_rt      = rt;
        issue_rt_used = rtu;
        issue_wr_en   = wr;
        issue_wnum    = wn;
        issue_is_load = ld;
        #1;
    endtask

    task automatic idle();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        branch_taken = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state with decode empty
        idle();
        check("rst_stall", d_stall, 0);
        check("rst_flush", d_flush, 0);
        check("rst_load_pc", d_load_pc, 1);
        check("rst_load_if_id", d_load_if_id, 1);
        check("rst_fwd_rs", d_fwd_rs, 0);
        check("rst_inflight", d_inflight, 0);
        check("rst_stall_cnt", d_stall_cnt, 0);
        tick();
        rst = 1'b1;
        #1;

        // ADD r3 then two dependents: forward from entry 0, then entry 1
        set_issue(1, 0, 0, 0, 0, 1, 5'd3, 0);
        check("add_issue_stall", d_stall, 0);
        tick();
        set_issue(1, 5'd3, 1, 0, 0, 1, 5'd8, 0);
        check("fwd1_stall", d_stall, 0);
        check("fwd1_rs_sel", d_fwd_rs, 1);
        check("fwd1_rt_sel", d_fwd_rt, 0);
        check("fwd1_inflight", d_inflight, 1);
        tick();
        set_issue(1, 5'd3, 1, 0, 0, 0, 5'd0, 0);
        check("fwd2_rs_sel", d_fwd_rs, 2);
        check("fwd2_inflight", d_inflight, 2);

        // Load-use on rt: one bubble then forward from entry 1
        do_reset();
        set_issue(1, 0, 0, 0, 0, 1, 5'd5, 1);
        tick();
        set_issue(1, 0, 0, 5'd5, 1, 1, 5'd9, 0);
        check("lu_stall", d_stall, 1);
        check("lu_load_pc", d_load_pc, 0);
        check("lu_load_if_id", d_load_if_id, 0);
        tick();
        check("lu_stall_cnt", d_stall_cnt, 1);
        check("lu_stall_released", d_stall, 0);
        check("lu_fwd_rt_sel", d_fwd_rt, 2);
        tick();
        idle();
        check("lu_stall_cnt_hold", d_stall_cnt, 1);

        // Stall-only build: ADD r4 then dependent holds for exactly 3 cycles
        do_reset();
        set_issue(1, 0, 0, 0, 0, 1, 5'd4, 0);
        tick();
        set_issue(1, 5'd4, 1, 0, 0, 0, 5'd0, 0);
        check("nf_def_fwd", d_fwd_rs, 1);
        check("nf_stall_c1", n_stall, 1);
        tick();
        check("nf_stall_c2", n_stall, 1);
        tick();
        check("nf_stall_c3", n_stall, 1);
        tick();
        check("nf_stall_done", n_stall, 0);
        check("nf_fwd_rs_sel", n_fwd_rs, 0);
        check("nf_stall_cnt", n_stall_cnt, 3);

        // Taken branch in entry 1 with a load r7 behind it and a load-use in decode
        do_reset();
        set_issue(1, 0, 0, 0, 0, 0, 5'd0, 0);
        tick();
        set_issue(1, 0, 0, 0, 0, 1, 5'd7, 1);
        tick();
        set_issue(1, 5'd7, 1, 0, 0, 1, 5'd9, 0);
        check("br_pre_stall", d_stall, 1);
        check("br_pre_inflight", d_inflight, 2);
        branch_taken = 1'b1;
        #1;
        check("br_flush", d_flush, 1);
        check("br_stall", d_stall, 0);
        check("br_load_pc", d_load_pc, 1);
        check("br_load_if_id", d_load_if_id, 1);
        tick();
        branch_taken = 1'b0;
        #1;
        check("br_inflight", d_inflight, 1);
        check("br_flush_cnt", d_flush_cnt, 1);
        check("br_stall_cnt", d_stall_cnt, 0);
        check("br_no_fwd", d_fwd_rs, 0);
        check("br_no_stall", d_stall, 0);

        // Register zero never creates a dependency
        do_reset();
        set_issue(1, 0, 0, 0, 0, 1, 5'd0, 1);
        tick();
        set_issue(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
        check("r0_stall", d_stall, 0);
        check("r0_fwd_rs", d_fwd_rs, 0);
        check("r0_fwd_rt", d_fwd_rt, 0);
        check("r0_nf_stall", n_stall, 0);
        tick();

        // Chain of five load-use stalls: 2-bit counter saturates at 3
        set_issue(1, 0, 0, 0, 0, 1, 5'd1, 1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            set_issue(1, 5'(i), 1, 0, 0, 1, 5'(i + 1), 1);
            tick();
            tick();
        end
        check("sat_c2_stall_cnt", c_stall_cnt, 3);
        check("sat_def_stall_cnt", d_stall_cnt, 5);
        idle();
        tick();
        tick();
        tick();

        // Asynchronous reset while three entries are valid and decode is stalled
        set_issue(1, 0, 0, 0, 0, 1, 5'd1, 0);
        tick();
        set_issue(1, 0, 0, 0, 0, 1, 5'd2, 0);
        tick();
        set_issue(1, 0, 0, 0, 0, 1, 5'd3, 1);
        tick();
        set_issue(1, 5'd3, 1, 0, 0, 0, 5'd0, 0);
        check("ar_pre_inflight", d_inflight, 3);
        check("ar_pre_stall", d_stall, 1);
        check("ar_pre_stall_cnt", d_stall_cnt, 5);
        #1;
        rst = 1'b0;
        #1;
        check("ar_inflight", d_inflight, 0);
        check("ar_stall", d_stall, 0);
        check("ar_stall_cnt", d_stall_cnt, 0);
        check("ar_flush_cnt", d_flush_cnt, 0);
        #1;
        rst = 1'b1;
        tick();
        check("ar_post_stall", d_stall, 0);
        check("ar_post_fwd", d_fwd_rs, 0);
        check("ar_post_inflight", d_inflight, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
